// File: rtl/hawk_axiwr_arb.sv
// Round-robin sharing of the 512-bit AXI write master; one write in flight, grant is combinational in IDLE.
// Best case 4 cycles grant-to-IDLE; AW/W valids hold (payload stable) until ready, a stalled write blocks all requesters.
module hawk_axiwr_arb #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 512,
  parameter int STRB_W  = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  input  logic [NUM_REQ*STRB_W-1:0] req_strb_i,
  output logic [NUM_REQ-1:0]        req_gnt_o,
  output logic [NUM_REQ-1:0]        resp_valid_o,
  output logic [1:0]                resp_bresp_o,
  output logic                      m_awvalid_o,
  output logic [ADDR_W-1:0]         m_awaddr_o,
  input  logic                      m_awready_i,
  output logic                      m_wvalid_o,
  output logic [DATA_W-1:0]         m_wdata_o,
  output logic [STRB_W-1:0]         m_wstrb_o,
  input  logic                      m_wready_i,
  input  logic                      m_bvalid_i,
  input  logic [1:0]                m_bresp_i,
  output logic                      m_bready_o,
  output logic                      busy_o,
  output logic [15:0]               err_cnt_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_B, RESP} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, idx_q, pick;
  logic               pick_vld;
  logic [15:0]        err_cnt_q;
  logic               aw_ok, w_ok;

  assign err_cnt_o = err_cnt_q;

  // First requester at or above rr_ptr, wrapping around.
  always_comb begin
    int j;
    j        = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!pick_vld && req_valid_i[IDX_W'(j)]) begin
        pick_vld = 1'b1;
        pick     = IDX_W'(j);
      end
    end
  end

  // A channel counts as done once its valid has already dropped or it handshakes now.
  assign aw_ok = !m_awvalid_o || m_awready_i;
  assign w_ok  = !m_wvalid_o  || m_wready_i;

  always_comb begin
    state_d   = state_q;
    req_gnt_o = '0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d         = SEND;
          req_gnt_o[pick] = 1'b1;
        end
      end
      SEND:    if (aw_ok && w_ok) state_d = WAIT_B;
      WAIT_B:  if (m_bvalid_i) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rst_i) req_gnt_o = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q     <= '0;
      idx_q        <= '0;
      m_awvalid_o  <= 1'b0;
      m_wvalid_o   <= 1'b0;
      m_awaddr_o   <= '0;
      m_wdata_o    <= '0;
      m_wstrb_o    <= '0;
      m_bready_o   <= 1'b0;
      resp_valid_o <= '0;
      resp_bresp_o <= '0;
      busy_o       <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      resp_valid_o <= '0;
      resp_bresp_o <= '0;
      busy_o       <= (state_d != IDLE);
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            idx_q       <= pick;
            m_awaddr_o  <= req_addr_i[int'(pick)*ADDR_W +: ADDR_W];
            m_wdata_o   <= req_data_i[int'(pick)*DATA_W +: DATA_W];
            m_wstrb_o   <= req_strb_i[int'(pick)*STRB_W +: STRB_W];
            m_awvalid_o <= 1'b1;
            m_wvalid_o  <= 1'b1;
          end
        end
        SEND: begin
          if (m_awready_i)    m_awvalid_o <= 1'b0;
          if (m_wready_i)     m_wvalid_o  <= 1'b0;
          if (aw_ok && w_ok)  m_bready_o  <= 1'b1;
        end
        WAIT_B: begin
          if (m_bvalid_i) begin
            m_bready_o          <= 1'b0;
            resp_valid_o[idx_q] <= 1'b1;
            resp_bresp_o        <= m_bresp_i;
            if (m_bresp_i != 2'b00 && err_cnt_q != 16'hFFFF)
              err_cnt_q <= err_cnt_q + 16'd1;
          end
        end
        RESP: begin
          rr_ptr_q <= (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
